apb_slave_regbank: RTL and testbench

- APB3 completer (slave): a 64-word register bank, one instance per slave port of the APB interconnect, with psel/penable driven by the interconnect's per-slave select.
- Decodes only the low byte of paddr, i.e. its own 256-byte window.
- Inserts programmable wait states.
- Flags misaligned accesses and writes to read-only locations with pslverr.

---
 rtl/apb_pkg.sv | 37 +++
 rtl/apb_wait_gen.sv | 78 +++++++
 rtl/apb_slave_regbank.sv | 208 ++++++++++++++++++++
 tb/tb_apb_slave_regbank.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared types and constants for the APB3 register-bank completer.
//   - apb_slv_state_e : completer FSM states
//   - APB_ADDR_W/DATA_W : APB bus widths
//   - APB_ERR_RDATA   : read data returned on an error response
//   - APB_ID_PREFIX   : upper 30 bits of the read-only ID register
// Configuration macro: APB_SLV_RANDOM_WAIT_EN adds the LFSR seed and step
// function used by the pseudo-random wait-state generator.
// ---------------------------------------------------------------------------
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  localparam logic [APB_DATA_W-1:0] APB_ERR_RDATA = 32'hDEAD_BEEF;

  // {APB_ID_PREFIX, SLAVE_ID} reads back as 32'hA5B0_000x.
  localparam logic [29:0] APB_ID_PREFIX = 30'h296C_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } apb_slv_state_e;

`ifdef APB_SLV_RANDOM_WAIT_EN
  localparam logic [15:0] APB_LFSR_SEED = 16'hACE1;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10), shift left.
  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction
`endif

endpackage

// File: rtl/apb_wait_gen.sv
// ---------------------------------------------------------------------------
// apb_wait_gen
// Wait-state counter for the APB completer. The counter is loaded when a
// setup phase is accepted and decremented once per WAIT cycle.
// Ports:
//   clk_i        : clock (APB pclk)
//   rst_n_i      : synchronous active-low reset
//   load_i       : accepted setup; load the counter
//   dec_i        : decrement the counter (FSM is in WAIT)
//   wait_zero_o  : counter is 0 (no wait states for this transfer)
//   wait_done_o  : counter is 1 or 0 (last wait cycle)
// Configuration macro: APB_SLV_RANDOM_WAIT_EN
//   defined   : load value is lfsr[1:0] (0..3), LFSR steps once per load
//   undefined : load value is the WAIT_CYCLES parameter
// ---------------------------------------------------------------------------
module apb_wait_gen
  import apb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic load_i,
  input  logic dec_i,
  output logic wait_zero_o,
  output logic wait_done_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic [3:0] load_val;

`ifdef APB_SLV_RANDOM_WAIT_EN
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = lfsr16_next(lfsr_q);
    end
  end

  // The value in the register at the moment of load is used, then it steps.
  assign load_val = {2'b00, lfsr_q[1:0]};

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      lfsr_q <= APB_LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign load_val = 4'(WAIT_CYCLES);
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val;
    end else if (dec_i && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign wait_zero_o = (cnt_q == 4'd0);
  assign wait_done_o = (cnt_q <= 4'd1);

endmodule

// File: rtl/apb_slave_regbank.sv
// ---------------------------------------------------------------------------
// apb_slave_regbank
// APB3 completer exposing NUM_REGS 32-bit words in a 256-byte window
// (only paddr[7:0] is decoded). Offset 0x00 is a read-only ID register.
// Programmable wait states; pslverr on misaligned access or write to ID.
// All outputs are registered.
// Ports:
//   pclk     : clock
//   presetn  : synchronous active-low reset
//   psel     : select from interconnect
//   penable  : access-phase strobe
//   pwrite   : 1 = write, 0 = read
//   paddr    : address, [7:0] decoded
//   pwdata   : write data
//   prdata   : read data, non-zero only in the response cycle of a read
//   pready   : one-cycle transfer completion
//   pslverr  : error response, only in the response cycle
// Configuration macro: APB_SLV_RANDOM_WAIT_EN (pseudo-random 0..3 wait
// states from an LFSR instead of WAIT_CYCLES).
// ---------------------------------------------------------------------------
module apb_slave_regbank
  import apb_pkg::*;
#(
  parameter logic [1:0]  SLAVE_ID    = 2'd2,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned NUM_REGS    = 64
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [APB_ADDR_W-1:0] paddr,
  input  logic [APB_DATA_W-1:0] pwdata,
  output logic [APB_DATA_W-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);

  apb_slv_state_e state_q;
  apb_slv_state_e state_d;

  // Transfer attributes captured in the setup phase; bus changes after that
  // are ignored.
  logic [7:0]            addr_q;
  logic                  write_q;
  logic [APB_DATA_W-1:0] wdata_q;

  logic [APB_DATA_W-1:0] regs_q [NUM_REGS];

  logic [APB_DATA_W-1:0] prdata_q;
  logic [APB_DATA_W-1:0] prdata_d;
  logic                  pready_q;
  logic                  pready_d;
  logic                  pslverr_q;
  logic                  pslverr_d;

  logic       cap_en;
  logic       wait_load;
  logic       wait_dec;
  logic       wait_zero;
  logic       wait_done;

  logic [5:0] idx;
  logic       in_range;
  logic       err_misalign;
  logic       err_ro;
  logic       err_any;
  logic       wr_commit;
  logic [APB_DATA_W-1:0] rd_value;

  logic unused_paddr_hi;
  assign unused_paddr_hi = ^paddr[APB_ADDR_W-1:8];

  // -------------------------------------------------------------------------
  // Wait-state generator
  // -------------------------------------------------------------------------
  apb_wait_gen #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_gen (
    .clk_i       (pclk),
    .rst_n_i     (presetn),
    .load_i      (wait_load),
    .dec_i       (wait_dec),
    .wait_zero_o (wait_zero),
    .wait_done_o (wait_done)
  );

  // -------------------------------------------------------------------------
  // Decode of the captured address
  // -------------------------------------------------------------------------
  assign idx          = addr_q[7:2];
  // Words beyond NUM_REGS read as 0 and swallow writes without an error.
  assign in_range     = (32'(idx) < NUM_REGS);
  assign err_misalign = (addr_q[1:0] != 2'b00);
  assign err_ro       = write_q && (idx == 6'd0);
  assign err_any      = err_misalign || err_ro;

  always_comb begin
    rd_value = '0;
    if (err_any) begin
      rd_value = APB_ERR_RDATA;
    end else if (idx == 6'd0) begin
      rd_value = {APB_ID_PREFIX, SLAVE_ID};
    end else if (in_range) begin
      rd_value = regs_q[idx];
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cap_en    = 1'b0;
    wait_load = 1'b0;
    wait_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        // penable without a preceding setup phase is not a transfer.
        if (psel && !penable) begin
          state_d   = SETUP;
          cap_en    = 1'b1;
          wait_load = 1'b1;
        end
      end
      SETUP: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (penable) begin
          state_d = wait_zero ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!psel) begin
          state_d = IDLE;
        end else begin
          wait_dec = 1'b1;
          if (wait_done) begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        // A new setup presented now is picked up from IDLE next cycle.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are computed from the next state so the registered values line
  // up with the RESP cycle itself.
  always_comb begin
    pready_d  = (state_d == RESP);
    pslverr_d = (state_d == RESP) && err_any;
    prdata_d  = '0;
    if ((state_d == RESP) && !write_q) begin
      prdata_d = rd_value;
    end
  end

  // Writes land at the end of the response cycle, so a reset or an
  // abandoned transfer never reaches the array.
  assign wr_commit = (state_q == RESP) && write_q && !err_any && in_range;

  // -------------------------------------------------------------------------
  // Sequential logic
  // -------------------------------------------------------------------------
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      if (cap_en) begin
        addr_q  <= paddr[7:0];
        write_q <= pwrite;
        wdata_q <= pwdata;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_commit) begin
      regs_q[idx] <= wdata_q;
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// ---------------------------------------------------------------------------
// tb_apb_slave_regbank
// Directed bench for apb_slave_regbank with SLAVE_ID=3, WAIT_CYCLES=2.
// With APB_SLV_RANDOM_WAIT_EN defined, the wait-count expectation comes from
// a reference LFSR seeded with 16'hACE1 and a 20-read sequence is run.
// ---------------------------------------------------------------------------
module tb_apb_slave_regbank;

  localparam int         WAIT_CYCLES = 2;
  localparam logic [1:0] SLAVE_ID    = 2'd3;

  logic        pclk;
  logic        presetn;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int checks = 0;
  int errors = 0;

  logic [15:0] lfsr_m;

  apb_slave_regbank #(
    .SLAVE_ID    (SLAVE_ID),
    .WAIT_CYCLES (WAIT_CYCLES),
    .NUM_REGS    (64)
  ) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected number of wait states for the next accepted setup.
  task automatic next_wait(output int w);
`ifdef APB_SLV_RANDOM_WAIT_EN
    w = int'(lfsr_m[1:0]);
    lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
`else
    w = WAIT_CYCLES;
`endif
  endtask

  // One complete transfer: setup, access until pready (bounded), release.
  task automatic apb_xfer(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input bit scramble, output int lat);
    int w;
    bit got;
    next_wait(w);
    @(posedge pclk); #1;
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    @(posedge pclk); #1;
    penable = 1'b1;
    if (scramble) begin
      paddr  = ~addr;
      pwdata = ~wdata;
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat <= 40) begin
      @(negedge pclk);
      if (pready === 1'b1) got = 1'b1;
      else lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(w + 1));
    if (got) begin
      check({tag, "_pslverr"}, {31'b0, pslverr}, {31'b0, exp_err});
      if (!wr) check({tag, "_prdata"}, prdata, exp_rdata);
    end
    @(posedge pclk); #1;
    psel    = 1'b0;
    penable = 1'b0;
    @(negedge pclk);
    check({tag, "_pready_drop"}, {31'b0, pready}, 32'd0);
    check({tag, "_prdata_idle"}, prdata, 32'd0);
    $display("xfer %s wr=%0b addr=%h wdata=%h prdata=%h pslverr=%0b lat=%0d",
             tag, wr, addr, wdata, prdata, pslverr, lat);
  endtask

  task automatic do_reset(input int cycles);
    @(posedge pclk); #1;
    presetn = 1'b0;
    psel    = 1'b0;
    penable = 1'b0;
    repeat (cycles) @(posedge pclk);
    #1;
    presetn = 1'b1;
    lfsr_m  = 16'hACE1;
  endtask

  initial begin
    int lat;
    bit seen;

    presetn = 1'b0;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    lfsr_m  = 16'hACE1;

    // Reset state
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check("rst_pready", {31'b0, pready}, 32'd0);
    check("rst_pslverr", {31'b0, pslverr}, 32'd0);
    check("rst_prdata", prdata, 32'd0);
    @(posedge pclk); #1;
    presetn = 1'b1;

    // penable without setup must be ignored
    psel    = 1'b1;
    penable = 1'b1;
    pwrite  = 1'b0;
    paddr   = 32'h0000_0000;
    seen    = 1'b0;
    repeat (5) begin
      @(negedge pclk);
      if (pready !== 1'b0) seen = 1'b1;
    end
    check("no_setup_pready", {31'b0, seen}, 32'd0);
    @(posedge pclk); #1;
    psel    = 1'b0;
    penable = 1'b0;
    $display("step penable_without_setup pready_seen=%0b", seen);

`ifdef APB_SLV_RANDOM_WAIT_EN
    do_reset(2);
    apb_xfer("rnd_id", 1'b0, 32'h0000_0000, 32'h0, 32'hA5B0_0003, 1'b0, 1'b0, lat);
    for (int i = 0; i < 20; i++) begin
      apb_xfer($sformatf("rnd_rd%0d", i), 1'b0, 32'h0000_0004, 32'h0, 32'h0, 1'b0, 1'b0, lat);
      check($sformatf("rnd_range%0d", i), {31'b0, (lat >= 1 && lat <= 4)}, 32'd1);
    end
`else
    // Write with bus scrambled during the access phase, then read back
    apb_xfer("wr08", 1'b1, 32'h0000_0008, 32'h1234_5678, 32'h0, 1'b0, 1'b1, lat);
    apb_xfer("rd08", 1'b0, 32'h0000_0008, 32'h0, 32'h1234_5678, 1'b0, 1'b0, lat);

    // ID register and write protection
    apb_xfer("rd_id", 1'b0, 32'h0000_0000, 32'h0, 32'hA5B0_0003, 1'b0, 1'b0, lat);
    apb_xfer("wr_id", 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, lat);
    apb_xfer("rd_id2", 1'b0, 32'h0000_0000, 32'h0, 32'hA5B0_0003, 1'b0, 1'b0, lat);

    // Misaligned accesses; upper address bits outside the window ignored
    apb_xfer("wr06", 1'b1, 32'h0000_0006, 32'h0000_00FF, 32'h0, 1'b1, 1'b0, lat);
    apb_xfer("rd04", 1'b0, 32'hFF00_0004, 32'h0, 32'h0, 1'b0, 1'b0, lat);
    apb_xfer("rd05", 1'b0, 32'h0000_0005, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b0, lat);
    apb_xfer("rd08b", 1'b0, 32'h0000_0008, 32'h0, 32'h1234_5678, 1'b0, 1'b0, lat);

    // Last word of the window
    apb_xfer("wrFC", 1'b1, 32'h0000_00FC, 32'h0BAD_F00D, 32'h0, 1'b0, 1'b0, lat);
    apb_xfer("rdFC", 1'b0, 32'h0000_00FC, 32'h0, 32'h0BAD_F00D, 1'b0, 1'b0, lat);

    // psel dropped during WAIT: no response, no commit
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h0000_CAFE;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge pclk);
      if (pready !== 1'b0) seen = 1'b1;
    end
    check("abort_pready", {31'b0, seen}, 32'd0);
    $display("step abort_write addr=10 pready_seen=%0b", seen);
    apb_xfer("rd10", 1'b0, 32'h0000_0010, 32'h0, 32'h0, 1'b0, 1'b0, lat);

    // Reset during WAIT of a write
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'h0000_0055;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    presetn = 1'b0;
    @(posedge pclk);
    @(negedge pclk);
    check("rstwait_pready", {31'b0, pready}, 32'd0);
    check("rstwait_prdata", prdata, 32'd0);
    @(negedge pclk);
    check("rstwait_pready2", {31'b0, pready}, 32'd0);
    @(posedge pclk); #1;
    presetn = 1'b1; psel = 1'b0; penable = 1'b0;
    $display("step reset_in_wait pready=%0b prdata=%h", pready, prdata);
    apb_xfer("rd20", 1'b0, 32'h0000_0020, 32'h0, 32'h0, 1'b0, 1'b0, lat);
    apb_xfer("rd08_rst", 1'b0, 32'h0000_0008, 32'h0, 32'h0, 1'b0, 1'b0, lat);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
